// File: rtl/pea_pkg.sv
// Polynomial Evaluation Accelerator shared definitions:
// modes, opcodes, status codes, command fields, FSM states.
package pea_pkg;

  localparam int WORD_W  = 16;
  localparam int RES_W   = 32;
  localparam int STAT_W  = 8;
  localparam int MAX_DEG = 15;
  localparam int NUM_VEC = 8;
  localparam int BUF_DEP = 32;

  localparam logic [2:0] MODE_GET_COMMAND = 3'd0;
  localparam logic [2:0] MODE_STP         = 3'd1;
  localparam logic [2:0] MODE_EVP         = 3'd2;
  localparam logic [2:0] MODE_EVB         = 3'd3;
  localparam logic [2:0] MODE_RST         = 3'd4;
  localparam logic [2:0] MODE_OUTPUT      = 3'd5;

  localparam logic [7:0] OP_STP = 8'h01;
  localparam logic [7:0] OP_EVP = 8'h02;
  localparam logic [7:0] OP_EVB = 8'h03;
  localparam logic [7:0] OP_RST = 8'h04;

  localparam logic [7:0] ST_OK        = 8'd0;
  localparam logic [7:0] ST_OVF       = 8'd1;
  localparam logic [7:0] ST_UNDEF_VEC = 8'd2;
  localparam logic [7:0] ST_BAD_CMD   = 8'd3;
  localparam logic [7:0] ST_BAD_DEG   = 8'd4;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 8;
  localparam int A_MSB    = 7;
  localparam int A_LSB    = 5;
  localparam int ARG2_MSB = 4;
  localparam int ARG2_LSB = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_RD,
    S_CMD_DEC,
    S_STP_RD,
    S_STP_WR,
    S_EV_RD,
    S_EV_LOAD,
    S_EV_HORNER,
    S_EV_STORE,
    S_RST_CLR,
    S_OUT_WR,
    S_DONE
  } state_t;

endpackage

// File: rtl/pea_horner_step.sv
// One Horner step: y = acc*x + c at 48 bits, low 32 bits out.
// Ports: acc, x, c in; y result, ovf when the full value exceeds 32 bits.
module pea_horner_step (
  input  logic [31:0] acc,
  input  logic [15:0] x,
  input  logic [15:0] c,
  output logic [31:0] y,
  output logic        ovf
);

  logic signed [47:0] acc_w;
  logic signed [47:0] x_w;
  logic signed [47:0] c_w;
  logic signed [47:0] full;

  assign acc_w = $signed({{16{acc[31]}}, acc});
  assign x_w   = $signed({{32{x[15]}}, x});
  assign c_w   = $signed({{32{c[15]}}, c});
  assign full  = acc_w * x_w + c_w;

  assign y   = full[31:0];
  assign ovf = full[47:31] != {17{full[31]}};

endmodule

// File: rtl/pea_invoke.sv
// PEA firing FSM: command decode, coefficient store, Horner eval, output.
// Ports: invoke/FC handshake, FIFO pop strobes, result/status pushes, mode outs.
module pea_invoke
  import pea_pkg::*;
#(
  parameter int word_size   = 16,
  parameter int result_size = 32,
  parameter int status_size = 8,
  parameter int max_degree  = 15,
  parameter int num_vectors = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   invoke,
  input  logic [word_size-1:0]   command_in,
  input  logic [word_size-1:0]   data_in,
  output logic                   command_rd_en,
  output logic                   data_rd_en,
  output logic [result_size-1:0] result_out,
  output logic                   result_wr_en,
  output logic [status_size-1:0] status_out,
  output logic                   status_wr_en,
  output logic [2:0]             next_mode_out,
  output logic [4:0]             b_out,
  output logic [3:0]             N_out,
  output logic                   FC
);

  state_t state, state_n;

  logic [15:0] coef [num_vectors][max_degree+1];
  logic [3:0]  deg  [num_vectors];
  logic [31:0] rbuf [BUF_DEP];
  logic [7:0]  sbuf [BUF_DEP];

  logic [num_vectors-1:0] valid;
  logic [2:0]  vec_a;
  logic [4:0]  cnt;
  logic [4:0]  xrem;
  logic [5:0]  count;
  logic [31:0] acc;
  logic [15:0] xr;
  logic [7:0]  st;

  logic [7:0] cmd_op;
  logic [2:0] cmd_a;
  logic [4:0] cmd_arg2;
  logic [2:0] dec_mode;
  logic       dec_bad;
  logic [7:0] dec_code;

  logic [31:0] h_y;
  logic        h_ovf;
  logic        stp_last;
  logic        out_last;

  assign cmd_op   = command_in[OP_MSB:OP_LSB];
  assign cmd_a    = command_in[A_MSB:A_LSB];
  assign cmd_arg2 = command_in[ARG2_MSB:ARG2_LSB];
  assign stp_last = cnt[3:0] == N_out;
  assign out_last = {1'b0, cnt} == count - 6'd1;

  // Horner walks c(N-1) down to c0; cnt holds the index plus one.
  pea_horner_step u_step (
    .acc (acc),
    .x   (xr),
    .c   (coef[vec_a][cnt[3:0] - 4'd1]),
    .y   (h_y),
    .ovf (h_ovf)
  );

  always_comb begin
    dec_bad  = 1'b0;
    dec_code = ST_OK;
    dec_mode = MODE_GET_COMMAND;
    case (cmd_op)
      OP_STP: begin
        if (cmd_arg2 > 5'd15) begin
          dec_bad  = 1'b1;
          dec_code = ST_BAD_DEG;
        end else begin
          dec_mode = MODE_STP;
        end
      end
      OP_EVP:  dec_mode = MODE_EVP;
      OP_EVB:  dec_mode = (cmd_arg2 == 5'd0) ? MODE_GET_COMMAND : MODE_EVB;
      OP_RST:  dec_mode = MODE_RST;
      default: begin
        dec_bad  = 1'b1;
        dec_code = ST_BAD_CMD;
      end
    endcase
    if (dec_bad) dec_mode = MODE_OUTPUT;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    command_rd_en = 1'b0;
    data_rd_en    = 1'b0;
    result_wr_en  = 1'b0;
    status_wr_en  = 1'b0;
    result_out    = '0;
    status_out    = '0;
    FC            = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (invoke) begin
          case (next_mode_out)
            MODE_GET_COMMAND: state_n = S_CMD_RD;
            MODE_STP:         state_n = S_STP_RD;
            MODE_EVP:         state_n = S_EV_RD;
            MODE_EVB:         state_n = S_EV_RD;
            MODE_RST:         state_n = S_RST_CLR;
            MODE_OUTPUT:
              state_n = (count == 6'd0) ? S_DONE : S_OUT_WR;
            default:          state_n = S_DONE;
          endcase
        end
      end
      S_CMD_RD: begin
        command_rd_en = 1'b1;
        state_n       = S_CMD_DEC;
      end
      S_CMD_DEC: state_n = S_DONE;
      S_STP_RD: begin
        data_rd_en = 1'b1;
        state_n    = S_STP_WR;
      end
      S_STP_WR: state_n = stp_last ? S_DONE : S_STP_RD;
      S_EV_RD: begin
        data_rd_en = 1'b1;
        state_n    = S_EV_LOAD;
      end
      S_EV_LOAD: begin
        if (!valid[vec_a] || deg[vec_a] == 4'd0) state_n = S_EV_STORE;
        else                                      state_n = S_EV_HORNER;
      end
      S_EV_HORNER: state_n = (cnt == 5'd1) ? S_EV_STORE : S_EV_HORNER;
      S_EV_STORE:  state_n = (xrem == 5'd1) ? S_DONE : S_EV_RD;
      S_RST_CLR:   state_n = S_DONE;
      S_OUT_WR: begin
        result_wr_en = 1'b1;
        status_wr_en = 1'b1;
        result_out   = rbuf[cnt];
        status_out   = sbuf[cnt];
        state_n      = out_last ? S_DONE : S_OUT_WR;
      end
      S_DONE: begin
        FC      = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_mode_out <= MODE_GET_COMMAND;
      b_out         <= '0;
      N_out         <= '0;
      valid         <= '0;
      count         <= '0;
      vec_a         <= '0;
      cnt           <= '0;
      xrem          <= '0;
      acc           <= '0;
      xr            <= '0;
      st            <= ST_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (invoke) begin
            cnt  <= '0;
            xrem <= (next_mode_out == MODE_EVB) ? b_out : 5'd1;
            if (next_mode_out == MODE_OUTPUT && count == 6'd0)
              next_mode_out <= MODE_GET_COMMAND;
          end
        end
        S_CMD_DEC: begin
          vec_a         <= cmd_a;
          next_mode_out <= dec_mode;
          if (dec_bad) begin
            count <= count + 6'd1;
            b_out <= 5'(count + 6'd1);
          end else if (dec_mode == MODE_STP) begin
            N_out <= cmd_arg2[3:0];
          end else if (dec_mode == MODE_EVB) begin
            b_out <= cmd_arg2;
          end
        end
        S_STP_WR: begin
          cnt <= cnt + 5'd1;
          if (stp_last) begin
            valid[vec_a]  <= 1'b1;
            next_mode_out <= MODE_GET_COMMAND;
          end
        end
        S_EV_LOAD: begin
          xr  <= data_in;
          cnt <= {1'b0, deg[vec_a]};
          if (valid[vec_a]) begin
            acc <= {{16{coef[vec_a][deg[vec_a]][15]}}, coef[vec_a][deg[vec_a]]};
            st  <= ST_OK;
          end else begin
            acc <= '0;
            st  <= ST_UNDEF_VEC;
          end
        end
        S_EV_HORNER: begin
          acc <= h_y;
          cnt <= cnt - 5'd1;
          if (h_ovf) st <= ST_OVF;
        end
        S_EV_STORE: begin
          count <= count + 6'd1;
          xrem  <= xrem - 5'd1;
          if (xrem == 5'd1) begin
            next_mode_out <= MODE_OUTPUT;
            b_out         <= 5'(count + 6'd1);
          end
        end
        S_RST_CLR: begin
          valid         <= '0;
          next_mode_out <= MODE_GET_COMMAND;
        end
        S_OUT_WR: begin
          cnt <= cnt + 5'd1;
          if (out_last) begin
            count         <= '0;
            next_mode_out <= MODE_GET_COMMAND;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage arrays carry no reset; valid bits and count gate their use.
  always_ff @(posedge clk) begin
    if (state == S_STP_WR) begin
      coef[vec_a][cnt[3:0]] <= data_in;
      if (stp_last) deg[vec_a] <= N_out;
    end
    if (state == S_EV_STORE) begin
      rbuf[count[4:0]] <= acc;
      sbuf[count[4:0]] <= st;
    end
    if (state == S_CMD_DEC && dec_bad) begin
      rbuf[count[4:0]] <= '0;
      sbuf[count[4:0]] <= dec_code;
    end
  end

endmodule

// File: tb/tb_pea_invoke.sv
// Scoreboard bench for pea_invoke: FIFO models, directed firings,
// a monitor popping expected (result,status) pairs on each write.
module tb_pea_invoke;
  import pea_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        invoke = 1'b0;
  logic [15:0] command_in = '0;
  logic [15:0] data_in = '0;
  logic        command_rd_en, data_rd_en;
  logic [31:0] result_out;
  logic        result_wr_en;
  logic [7:0]  status_out;
  logic        status_wr_en;
  logic [2:0]  next_mode_out;
  logic [4:0]  b_out;
  logic [3:0]  N_out;
  logic        FC;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  logic [15:0] cmd_q[$];
  logic [15:0] dat_q[$];
  logic [39:0] exp_q[$];

  pea_invoke dut (
    .clk(clk), .rst(rst), .invoke(invoke),
    .command_in(command_in), .data_in(data_in),
    .command_rd_en(command_rd_en), .data_rd_en(data_rd_en),
    .result_out(result_out), .result_wr_en(result_wr_en),
    .status_out(status_out), .status_wr_en(status_wr_en),
    .next_mode_out(next_mode_out), .b_out(b_out), .N_out(N_out),
    .FC(FC)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // FIFO heads: popped token appears before the DUT samples it.
  always @(negedge clk) begin
    if (command_rd_en) begin
      checks++;
      if (cmd_q.size() == 0) begin
        errors++;
        $display("FAIL cmd_fifo: pop from empty queue");
      end else command_in = cmd_q.pop_front();
    end
    if (data_rd_en) begin
      pops++;
      checks++;
      if (dat_q.size() == 0) begin
        errors++;
        $display("FAIL data_fifo: pop from empty queue");
      end else data_in = dat_q.pop_front();
    end
  end

  // Monitor: compare every output write against the scoreboard.
  always @(negedge clk) begin
    if (result_wr_en) begin
      logic [39:0] e;
      checks++;
      if (!status_wr_en) begin
        errors++;
        $display("FAIL out_strobe: status_wr_en 0 expected 1");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_extra: got %0h/%0h expected none",
                 result_out, status_out);
      end else begin
        e = exp_q.pop_front();
        if ({result_out, status_out} !== e) begin
          errors++;
          $display("FAIL out_entry: got %0h/%0h expected %0h/%0h",
                   result_out, status_out, e[39:8], e[7:0]);
        end
      end
    end
  end

  task automatic fire(output int lat);
    @(negedge clk) invoke = 1'b1;
    @(negedge clk) invoke = 1'b0;
    lat = 1;
    while (!FC && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!FC) chk("fc_timeout", 32'(lat), 32'd0);
  endtask

  task automatic cmd(logic [15:0] c, logic [2:0] m, int b, int n);
    int lat;
    cmd_q.push_back(c);
    fire(lat);
    chk("getcmd_latency", 32'(lat), 32'd3);
    chk("getcmd_mode", 32'(next_mode_out), 32'(m));
    if (b >= 0) chk("getcmd_b", 32'(b_out), 32'(b));
    if (n >= 0) chk("getcmd_n", 32'(N_out), 32'(n));
  endtask

  task automatic chk_reset_outs(string n);
    chk({n, "_strobes"},
        32'({command_rd_en, data_rd_en, result_wr_en, status_wr_en, FC}), 0);
    chk({n, "_mode"}, 32'(next_mode_out), 32'(MODE_GET_COMMAND));
    chk({n, "_b"}, 32'(b_out), 0);
    chk({n, "_n"}, 32'(N_out), 0);
    chk({n, "_res"}, result_out, 0);
    chk({n, "_stat"}, 32'(status_out), 0);
  endtask

  initial begin
    int lat;
    int p0;
    int w;
    bit fc_seen;
    longint v;

    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;

    // STP A=2 N=2: c0=1 c1=2 c2=3
    cmd(16'h0142, MODE_STP, -1, 2);
    dat_q.push_back(16'd1); dat_q.push_back(16'd2); dat_q.push_back(16'd3);
    p0 = pops;
    fire(lat);
    chk("stp_pops", 32'(pops - p0), 32'd3);
    chk("stp_mode", 32'(next_mode_out), 32'(MODE_GET_COMMAND));

    // EVP A=2 x=2 -> 3*4+2*2+1 = 17
    cmd(16'h0240, MODE_EVP, -1, -1);
    dat_q.push_back(16'd2);
    fire(lat);
    chk("evp_mode", 32'(next_mode_out), 32'(MODE_OUTPUT));
    chk("evp_b", 32'(b_out), 32'd1);
    exp_q.push_back({32'd17, 8'd0});
    fire(lat);
    chk("out_mode", 32'(next_mode_out), 32'(MODE_GET_COMMAND));

    // EVB A=2 x=-1,0,5 -> 2,1,86
    cmd(16'h0343, MODE_EVB, 3, -1);
    dat_q.push_back(16'hFFFF); dat_q.push_back(16'd0); dat_q.push_back(16'd5);
    fire(lat);
    chk("evb_mode", 32'(next_mode_out), 32'(MODE_OUTPUT));
    chk("evb_b", 32'(b_out), 32'd3);
    exp_q.push_back({32'd2, 8'd0});
    exp_q.push_back({32'd1, 8'd0});
    exp_q.push_back({32'd86, 8'd0});
    fire(lat);
    chk("evb_out_lat", 32'(lat), 32'd4);

    // Overflow: x^3 * 32767 at x=32767; result is 32767^4 mod 2^32
    cmd(16'h0103, MODE_STP, -1, 3);
    dat_q.push_back(16'd0); dat_q.push_back(16'd0);
    dat_q.push_back(16'd0); dat_q.push_back(16'd32767);
    fire(lat);
    cmd(16'h0200, MODE_EVP, -1, -1);
    dat_q.push_back(16'd32767);
    fire(lat);
    chk("ovf_b", 32'(b_out), 32'd1);
    v = 64'd32767;
    v = v * v * v * v;
    exp_q.push_back({v[31:0], 8'd1});
    fire(lat);

    // RST then EVP on A=0 -> undefined vector, x still popped
    cmd(16'h0400, MODE_RST, -1, -1);
    fire(lat);
    chk("rst_mode", 32'(next_mode_out), 32'(MODE_GET_COMMAND));
    cmd(16'h0200, MODE_EVP, -1, -1);
    dat_q.push_back(16'd4);
    p0 = pops;
    fire(lat);
    chk("undef_pops", 32'(pops - p0), 32'd1);
    exp_q.push_back({32'd0, 8'd2});
    fire(lat);

    // Invalid opcode and bad degree
    p0 = pops;
    cmd(16'hFF00, MODE_OUTPUT, 1, -1);
    chk("badcmd_pops", 32'(pops - p0), 32'd0);
    exp_q.push_back({32'd0, 8'd3});
    fire(lat);
    cmd(16'h0114, MODE_OUTPUT, 1, -1);
    exp_q.push_back({32'd0, 8'd4});
    fire(lat);

    // Restore A=2 so the aborted EVB really evaluates
    cmd(16'h0142, MODE_STP, -1, 2);
    dat_q.push_back(16'd1); dat_q.push_back(16'd2); dat_q.push_back(16'd3);
    fire(lat);

    // Reset mid-EVB after the 2nd x: no FC, outputs to reset values
    cmd(16'h0343, MODE_EVB, 3, -1);
    dat_q.push_back(16'd10); dat_q.push_back(16'd11); dat_q.push_back(16'd12);
    p0 = pops;
    fc_seen = 1'b0;
    @(negedge clk) invoke = 1'b1;
    @(negedge clk) invoke = 1'b0;
    w = 0;
    while (pops - p0 < 2 && w < 100) begin
      @(negedge clk);
      if (FC) fc_seen = 1'b1;
      w++;
    end
    chk("abort_pops", 32'(pops - p0), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("abort");
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (FC) fc_seen = 1'b1;
    end
    chk("abort_no_fc", 32'(fc_seen), 32'd0);
    dat_q.delete();

    // Valid bits cleared by reset: A=2 now undefined
    cmd(16'h0240, MODE_EVP, -1, -1);
    dat_q.push_back(16'd7);
    fire(lat);
    exp_q.push_back({32'd0, 8'd2});
    fire(lat);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
